// File: rtl/pfd_deglitch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pfd_deglitch_pkg
//  Description : Shared mode encodings and helper function for the PFD
//                synchroniser / glitch filter.
//  Revision    : 1.0  initial release
// ============================================================================
package pfd_deglitch_pkg;

   // Filter mode encodings; 2'd3 is treated the same as MODE_INT
   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_MAJ    = 2'd1;
   localparam logic [1:0] MODE_INT    = 2'd2;

   // Two-out-of-three vote
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pfd_deglitch_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pfd_deglitch_channel
//  Description : One channel: synchroniser chain, 3-sample history,
//                saturating integrator, filtered level and edge pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module pfd_deglitch_channel #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] thr_on,
   input  logic [CNT_W-1:0] thr_off,
   input  logic             cfg_err,
   input  logic             sig_in,
   output logic             sig_out,
   output logic             rise,
   output logic             fall
);
   import pfd_deglitch_pkg::*;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d1;
   logic                   r_s_d2;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_sig_out;
   logic                   r_rise;
   logic                   r_fall;

   logic                   w_s;
   logic                   w_maj;
   logic                   w_use_int;
   logic [CNT_W-1:0]       w_cnt_next;
   logic                   w_out_next;

   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_maj     = maj3(w_s, r_s_d1, r_s_d2);
   // A bad threshold pair demotes the integrator to the majority vote
   assign w_use_int = mode[1] & ~cfg_err;

   // Shift the raw input through the synchroniser chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
   end

   // Keep the two previous synchronised samples for the majority vote
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s_d1 <= 1'b0;
         r_s_d2 <= 1'b0;
      end else begin
         r_s_d1 <= w_s;
         r_s_d2 <= r_s_d1;
      end
   end

   // Saturating up/down count of the synchronised level, never wraps
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_s && (r_cnt != c_cnt_max))
         w_cnt_next = r_cnt + c_cnt_one;
      else if (!w_s && (r_cnt != '0))
         w_cnt_next = r_cnt - c_cnt_one;
   end

   // Select the next filtered level for the active mode; integrator holds between thresholds
   always_comb begin
      w_out_next = r_sig_out;
      if (mode == MODE_BYPASS)
         w_out_next = w_s;
      else if (!w_use_int)
         w_out_next = w_maj;
      else if (w_cnt_next >= thr_on)
         w_out_next = 1'b1;
      else if (w_cnt_next <= thr_off)
         w_out_next = 1'b0;
   end

   // Register counter, level and the edge pulses derived from the level change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_sig_out <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_sig_out <= w_out_next;
         r_rise    <= w_out_next & ~r_sig_out;
         r_fall    <= ~w_out_next & r_sig_out;
      end
   end

   assign sig_out = r_sig_out;
   assign rise    = r_rise;
   assign fall    = r_fall;

endmodule
`default_nettype wire

// File: rtl/pfd_deglitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pfd_deglitch_filter
//  Description : N-channel synchroniser and glitch filter for asynchronous
//                PFD UP/DN pulses; shared configuration check.
//  Revision    : 1.0  initial release
// ============================================================================
module pfd_deglitch_filter #(
   parameter int CH          = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] thr_on,
   input  logic [CNT_W-1:0] thr_off,
   input  logic [CH-1:0]    sig_in,
   output logic [CH-1:0]    sig_out,
   output logic [CH-1:0]    rise,
   output logic [CH-1:0]    fall,
   output logic             cfg_err
);
   import pfd_deglitch_pkg::*;

   logic r_cfg_err;

   // Flag a threshold pair without positive hysteresis, re-evaluated every cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cfg_err <= 1'b0;
      else       r_cfg_err <= (thr_on <= thr_off);
   end

   assign cfg_err = r_cfg_err;

   generate
      for (genvar i = 0; i < CH; i++) begin : g_ch
         pfd_deglitch_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
         ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .mode    (mode),
            .thr_on  (thr_on),
            .thr_off (thr_off),
            .cfg_err (r_cfg_err),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pfd_deglitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pfd_deglitch_filter
//  Description : Scoreboard bench for pfd_deglitch_filter with a behavioural
//                reference model, directed scenarios and random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pfd_deglitch_filter;

   localparam int CH   = 2;
   localparam int SS   = 2;
   localparam int CW   = 4;
   localparam int MAXC = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    mode;
   logic [CW-1:0] thr_on;
   logic [CW-1:0] thr_off;
   logic [CH-1:0] sig_in;
   logic [CH-1:0] sig_out;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic          cfg_err;

   pfd_deglitch_filter #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset   (reset),
      .mode    (mode),
      .thr_on  (thr_on),
      .thr_off (thr_off),
      .sig_in  (sig_in),
      .sig_out (sig_out),
      .rise    (rise),
      .fall    (fall),
      .cfg_err (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0] out;
      logic [CH-1:0] rs;
      logic [CH-1:0] fl;
      logic          cfg;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: input samples seen at past edges, counter as plain integer
   logic m_samp [CH][SS+2];
   int   m_cnt  [CH];
   logic m_out  [CH];
   logic m_cfg;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < SS + 2; k++) m_samp[c][k] = 1'b0;
         m_cnt[c] = 0;
         m_out[c] = 1'b0;
      end
      m_cfg = 1'b0;
   endtask

   // One active edge: s is the input sampled SS edges ago, history the two before it
   task automatic model_edge();
      exp_t e;
      logic cfg_prev;
      logic s, d1, d2, nxt;
      int   ones;
      cfg_prev = m_cfg;
      e = '0;
      for (int c = 0; c < CH; c++) begin
         s    = m_samp[c][SS-1];
         d1   = m_samp[c][SS];
         d2   = m_samp[c][SS+1];
         ones = int'(s) + int'(d1) + int'(d2);
         if (s) m_cnt[c] = (m_cnt[c] + 1 > MAXC) ? MAXC : m_cnt[c] + 1;
         else   m_cnt[c] = (m_cnt[c] - 1 < 0) ? 0 : m_cnt[c] - 1;
         nxt = m_out[c];
         if (mode == 2'd0)                   nxt = s;
         else if (mode == 2'd1 || cfg_prev)  nxt = (ones >= 2);
         else if (m_cnt[c] >= int'(thr_on))  nxt = 1'b1;
         else if (m_cnt[c] <= int'(thr_off)) nxt = 1'b0;
         e.rs[c]  = nxt & ~m_out[c];
         e.fl[c]  = ~nxt & m_out[c];
         e.out[c] = nxt;
         m_out[c] = nxt;
         for (int k = SS + 1; k > 0; k--) m_samp[c][k] = m_samp[c][k-1];
         m_samp[c][0] = sig_in[c];
      end
      m_cfg = (thr_on <= thr_off);
      e.cfg = m_cfg;
      sb_q.push_back(e);
   endtask

   // Monitor: every pushed expectation is compared against the outputs mid-cycle
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         checks++;
         if ({sig_out, rise, fall, cfg_err} !== mon_e) begin
            errors++;
            $display("FAIL cycle_check t=%0t got out=%b rise=%b fall=%b cfg=%b exp out=%b rise=%b fall=%b cfg=%b",
                     $time, sig_out, rise, fall, cfg_err, mon_e.out, mon_e.rs, mon_e.fl, mon_e.cfg);
         end
      end
   end

   task automatic check_zero(input string name);
      checks++;
      if ({sig_out, rise, fall, cfg_err} !== '0) begin
         errors++;
         $display("FAIL %s got out=%b rise=%b fall=%b cfg=%b exp all 0",
                  name, sig_out, rise, fall, cfg_err);
      end
   endtask

   // Drive one cycle of input from a negedge; leaves the caller at the next negedge
   task automatic cyc(input logic [CH-1:0] v);
      sig_in = v;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic run(input logic [CH-1:0] v, input int n);
      for (int i = 0; i < n; i++) cyc(v);
   endtask

   // Asynchronous reset pulse away from the clock edge, checked before any edge
   task automatic pulse_reset();
      #2;
      reset = 1'b1;
      #1;
      check_zero("async_reset_clear");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [CH-1:0] rv;
      reset   = 1'b1;
      mode    = 2'd0;
      thr_on  = 4'd6;
      thr_off = 4'd2;
      sig_in  = '0;
      model_reset();
      #1;
      check_zero("power_on_reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Quiet inputs in every mode, then bypass latency on channel 0
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         run(2'b00, 4);
      end
      mode = 2'd0;
      run(2'b01, 5);
      run(2'b00, 5);

      // Majority: 1-cycle glitch rejected, 2-cycle pulse passed
      mode = 2'd1;
      cyc(2'b10);
      run(2'b00, 6);
      run(2'b10, 2);
      run(2'b00, 6);

      // Integrator: rise, hysteresis hold, fall
      mode = 2'd2;
      run(2'b01, 20);
      run(2'b00, 3);
      run(2'b00, 20);

      // Saturation at the top and bottom of the counter
      run(2'b01, 40);
      run(2'b00, 13);
      run(2'b00, 20);

      // Equal thresholds: integrator falls back to majority, then recovers
      thr_on  = 4'd3;
      thr_off = 4'd3;
      cyc(2'b01);
      run(2'b00, 4);
      run(2'b01, 5);
      run(2'b00, 5);
      thr_on = 4'd6;
      run(2'b01, 12);
      run(2'b00, 15);

      // Reset mid-count with the output high, then independent channel patterns
      mode = 2'd3;
      run(2'b01, 9);
      run(2'b00, 2);
      pulse_reset();
      for (int i = 0; i < 30; i++) cyc({(i % 3) == 0, (i % 5) < 2});

      // Randomised traffic with occasional reconfiguration and reset
      rv = '0;
      for (int i = 0; i < 1500; i++) begin
         if ((i % 60) == 0) begin
            mode   = 2'($urandom_range(3));
            thr_on = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) thr_off = thr_on;
            else                        thr_off = 4'($urandom_range(15));
         end
         for (int c = 0; c < CH; c++)
            if ($urandom_range(3) == 0) rv[c] = ~rv[c];
         if ($urandom_range(400) == 0) pulse_reset();
         cyc(rv);
      end

      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
